// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : Single-outstanding request/response bridge to an asynchronous
//             SRAM pin driver. Each accepted request performs one word access
//             that keeps the SRAM enable high for WAIT_CYCLES clocks. The
//             result is then held until upstream takes it.
//  Ports    : clock, reset_n          - clock, async active-low reset
//             io_req_*                - request channel (valid/ready)
//             io_resp_*               - response channel (valid/ready)
//             io_sram_*               - SRAM pin-driver side
//  Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1     // enable-high cycles per access, 1..15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [21:0] io_req_addr,
    input  logic        io_req_wen,
    input  logic [31:0] io_req_wdata,
    input  logic [3:0]  io_req_wmask,
    output logic        io_resp_valid,
    input  logic        io_resp_ready,
    output logic [31:0] io_resp_rdata,
    output logic [19:0] io_sram_addr,
    output logic [31:0] io_sram_din,
    input  logic [31:0] io_sram_dout,
    output logic        io_sram_en,
    output logic        io_sram_we,
    output logic [3:0]  io_sram_wmask
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_load = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_wen;
    logic        w_wen_nxt;
    logic [3:0]  r_mask;
    logic [3:0]  w_mask_nxt;
    logic [19:0] r_sram_addr;
    logic [19:0] w_addr_nxt;
    logic [31:0] r_sram_din;
    logic [31:0] w_din_nxt;
    logic [31:0] r_resp_rdata;
    logic [31:0] w_rdata_nxt;
    logic        r_sram_en;
    logic        r_sram_we;
    logic [3:0]  r_sram_wmask;
    logic        r_resp_valid;
    logic        r_req_ready;
    logic        w_accept;
    logic        w_in_access_nxt;

    // Byte-offset bits are not used: accesses are always whole words.
    logic        w_addr_unused;
    assign w_addr_unused = ^io_req_addr[1:0];

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && io_req_valid;

    // ------------------------------------------------------------------
    // Next-state and next-register computation
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wen_nxt   = r_wen;
        w_mask_nxt  = r_mask;
        w_addr_nxt  = r_sram_addr;
        w_din_nxt   = r_sram_din;
        w_rdata_nxt = r_resp_rdata;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_wen_nxt  = io_req_wen;
                    w_mask_nxt = io_req_wmask;
                    w_addr_nxt = io_req_addr[21:2];
                    w_din_nxt  = io_req_wdata;
                    // A write that enables no byte has nothing to do on the
                    // bus, so it is answered immediately.
                    if (io_req_wen && (io_req_wmask == 4'h0)) begin
                        w_state_nxt = ST_RESP;
                        w_cnt_nxt   = 4'h0;
                        w_rdata_nxt = 32'h0;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'h0) begin
                    w_state_nxt = ST_RESP;
                    w_rdata_nxt = r_wen ? 32'h0 : io_sram_dout;
                end else begin
                    w_cnt_nxt = r_cnt - 4'h1;
                end
            end
            ST_RESP: begin
                if (io_resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself; outside ACCESS the bus controls read as 0.
    assign w_in_access_nxt = (w_state_nxt == ST_ACCESS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'h0;
            r_wen         <= 1'b0;
            r_mask        <= 4'h0;
            r_sram_addr   <= 20'h0;
            r_sram_din    <= 32'h0;
            r_resp_rdata  <= 32'h0;
            r_sram_en     <= 1'b0;
            r_sram_we     <= 1'b0;
            r_sram_wmask  <= 4'h0;
            r_resp_valid  <= 1'b0;
            r_req_ready   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wen         <= w_wen_nxt;
            r_mask        <= w_mask_nxt;
            r_sram_addr   <= w_addr_nxt;
            r_sram_din    <= w_din_nxt;
            r_resp_rdata  <= w_rdata_nxt;
            r_sram_en     <= w_in_access_nxt;
            r_sram_we     <= w_in_access_nxt && w_wen_nxt;
            r_sram_wmask  <= (w_in_access_nxt && w_wen_nxt) ? w_mask_nxt : 4'h0;
            r_resp_valid  <= (w_state_nxt == ST_RESP);
            r_req_ready   <= (w_state_nxt == ST_IDLE);
        end
    end

    assign io_req_ready  = r_req_ready;
    assign io_resp_valid = r_resp_valid;
    assign io_resp_rdata = r_resp_rdata;
    assign io_sram_addr  = r_sram_addr;
    assign io_sram_din   = r_sram_din;
    assign io_sram_en    = r_sram_en;
    assign io_sram_we    = r_sram_we;
    assign io_sram_wmask = r_sram_wmask;

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SHALL set the number of cycles io_sram_en is held per access; legal range is 1..15.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-004 io_req_valid  input  1  SHALL mean an upstream request is present.
REQ-005 io_req_ready  output  1  SHALL mean the controller accepts a request this cycle.
REQ-006 io_req_addr  input  22  SHALL carry the byte address; bits [1:0] SHALL be ignored.
REQ-007 io_req_wen  input  1  SHALL select write (1) or read (0).
REQ-008 io_req_wdata  input  32  SHALL carry the write data.
REQ-009 io_req_wmask  input  4  SHALL carry the byte enables (bit i = byte i), active-high.
REQ-010 io_resp_valid  output  1  SHALL mean a response is present.
REQ-011 io_resp_ready  input  1  SHALL mean upstream consumes the response.
REQ-012 io_resp_rdata  output  32  SHALL carry read data; 0 for writes.
REQ-013 io_sram_addr  output  20  SHALL carry the word address to the SRAM pin driver.
REQ-014 io_sram_din  output  32  SHALL carry the write data to the SRAM pin driver.
REQ-015 io_sram_dout  input  32  SHALL carry the read data from the SRAM pin driver.
REQ-016 io_sram_en  output  1  SHALL be the access enable.
REQ-017 io_sram_we  output  1  SHALL be the write select; it is meaningful only while io_sram_en=1.
REQ-018 io_sram_wmask  output  4  SHALL carry the byte enables, active-high.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP; all io_sram_* and io_resp_* outputs SHALL be driven from registers.
REQ-020 io_req_ready SHALL be 1 only in IDLE.
REQ-021 On an IDLE edge with io_req_valid=1, the controller SHALL latch addr[21:2], wen, wdata and wmask, then go to ACCESS with the counter loaded to WAIT_CYCLES-1.
REQ-022 In ACCESS, io_sram_en SHALL be 1, io_sram_we SHALL equal the latched wen, and io_sram_addr/din SHALL hold the latched values, stable for the whole access.
REQ-023 In ACCESS, io_sram_wmask SHALL equal the latched mask for writes and 4'h0 for reads.
REQ-024 Each ACCESS cycle SHALL decrement the counter; at counter=0 the FSM SHALL go to RESP, so io_sram_en is high for exactly WAIT_CYCLES cycles.
REQ-025 For reads, io_resp_rdata SHALL capture io_sram_dout on the edge that leaves ACCESS; for writes it SHALL be loaded with 0.
REQ-026 A write with wmask=4'h0 SHALL skip ACCESS, go directly IDLE->RESP with rdata=0, and never assert io_sram_en.
REQ-027 In RESP, io_resp_valid SHALL be 1, and io_resp_rdata SHALL stay stable until io_resp_ready=1.
REQ-028 The handshake edge in RESP SHALL return the FSM to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-029 Outside ACCESS, io_sram_en, io_sram_we and io_sram_wmask SHALL be 0, which guarantees at least one bus-idle cycle between accesses (write->read turnaround).
REQ-030 Latency SHALL be: request accepted at edge T, io_sram_en high during cycles T+1..T+W, io_resp_valid high from cycle T+W+1 (W = WAIT_CYCLES).
REQ-031 Peak throughput SHALL be one access per W+2 cycles.
REQ-032 io_req_valid deasserting, or request fields changing, after acceptance SHALL NOT affect the access in flight.

Reset
REQ-033 On reset_n=0, the FSM SHALL go to IDLE immediately, independent of clock, including mid-ACCESS or mid-RESP, and the in-flight transaction SHALL be dropped.
REQ-034 During and after reset: io_sram_en=0, io_sram_we=0, io_sram_wmask=0, io_sram_addr=0, io_sram_din=0, io_resp_valid=0, io_resp_rdata=0, counter=0.
REQ-035 io_req_ready SHALL be 1 from the first edge after reset_n rises.

Verification
REQ-036 W=1: read addr 0x000010, SRAM model returns 0xDEADBEEF -> io_sram_addr=0x00004, en high 1 cycle with we=0 and wmask=0, resp_valid at T+2 with rdata=0xDEADBEEF.
REQ-037 W=3: write addr 0x3FFFFC, wdata 0x12345678, wmask 4'b0101 -> en=1, we=1 for exactly 3 cycles with addr=0xFFFFF and wmask=4'b0101; resp rdata=0.
REQ-038 Write with wmask=0 -> en never asserted, resp_valid at T+1 with rdata=0.
REQ-039 Hold io_resp_ready=0 for 5 cycles after a read -> resp_valid and rdata stable, req_ready=0 and en=0 throughout; back-to-back write then read -> at least one en=0 cycle between them.
REQ-040 Assert reset_n=0 asynchronously on the 2nd ACCESS cycle with W=3 -> en drops in the same cycle, no resp_valid, req_ready=1 on the first edge after release.
